// File: rtl/adc_modulation_pkg.sv
// Shared definitions for the multi-slope run-up/run-down modulator:
// reference-mux codes, FSM state encoding and the mux-decision helper.
package adc_modulation_pkg;

    localparam logic [3:0] REFMUX_NONE  = 4'b0000;
    localparam logic [3:0] REFMUX_POS   = 4'b0001;
    localparam logic [3:0] REFMUX_NEG   = 4'b0010;
    localparam logic [3:0] REFMUX_RESET = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUNUP   = 3'd2,
        ST_RUNDOWN = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Integrator above zero -> pull it down with NEG, otherwise push up with POS.
    function automatic logic [3:0] refmux_for(input logic cmpr);
        return cmpr ? REFMUX_NEG : REFMUX_POS;
    endfunction

endpackage

// File: rtl/adc_modulation_cmpr_sync.sv
// Two-flop synchroniser for the asynchronous comparator output.
module cmpr_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_modulation.sv
// Multi-slope modulator: sequences integrator reset, run-up and run-down,
// counts reference periods and run-down clocks, publishes on a valid pulse.
module adc_modulation
    import adc_modulation_pkg::*;
#(
    parameter int PERIOD_MIN = 4,
    parameter int CW         = 24
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start_i,
    input  logic          cmpr_i,
    input  logic [23:0]   p_clk_count_reset,
    input  logic [31:0]   p_clk_count_aperture,
    input  logic [15:0]   p_clk_count_period,
    output logic [3:0]    refmux_o,
    output logic          cmpr_latch_o,
    output logic          sig_sw_o,
    output logic          busy_o,
    output logic          meas_valid_o,
    output logic [CW-1:0] count_pos_o,
    output logic [CW-1:0] count_neg_o,
    output logic [CW-1:0] count_rundown_o,
    output logic [31:0]   count_sig_o,
    output logic          overflow_o,
    output logic [2:0]    state_o
);

    localparam logic [15:0] PMIN = 16'(PERIOD_MIN);

    logic cmpr_s;

    cmpr_sync u_cmpr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (cmpr_i),
        .q_o     (cmpr_s)
    );

    state_e        state_q, state_d;
    logic [23:0]   sh_reset_q, sh_reset_d;
    logic [31:0]   sh_ap_q, sh_ap_d;
    logic [15:0]   sh_per_q, sh_per_d;
    logic [23:0]   rst_cnt_q, rst_cnt_d;
    logic [15:0]   per_cnt_q, per_cnt_d;
    logic [31:0]   sig_cnt_q, sig_cnt_d;
    logic [CW-1:0] pos_q, pos_d, neg_q, neg_d, rd_q, rd_d;
    logic          dir_q, dir_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    refmux_q, refmux_d;
    logic          latch_q, latch_d;
    logic          sig_sw_q, sig_sw_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cpos_q, cpos_d, cneg_q, cneg_d, crd_q, crd_d;
    logic [31:0]   csig_q, csig_d;
    logic          covf_q, covf_d;
    logic          new_period;
    logic          reset_last;
    logic          period_last;

    // A programmed reset count of 0 still spends one clock in RESET.
    assign reset_last  = (sh_reset_q == 24'd0) || (rst_cnt_q == sh_reset_q - 24'd1);
    assign period_last = (per_cnt_q == sh_per_q - 16'd1);

    always_comb begin
        state_d    = state_q;
        sh_reset_d = sh_reset_q;
        sh_ap_d    = sh_ap_q;
        sh_per_d   = sh_per_q;
        rst_cnt_d  = rst_cnt_q;
        per_cnt_d  = per_cnt_q;
        sig_cnt_d  = sig_cnt_q;
        pos_d      = pos_q;
        neg_d      = neg_q;
        rd_d       = rd_q;
        dir_d      = dir_q;
        ovf_d      = ovf_q;
        sig_sw_d   = sig_sw_q;
        cpos_d     = cpos_q;
        cneg_d     = cneg_q;
        crd_d      = crd_q;
        csig_d     = csig_q;
        covf_d     = covf_q;
        valid_d    = 1'b0;
        new_period = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sh_reset_d = p_clk_count_reset;
                    sh_ap_d    = p_clk_count_aperture;
                    sh_per_d   = (p_clk_count_period < PMIN) ? PMIN : p_clk_count_period;
                    rst_cnt_d  = '0;
                    per_cnt_d  = '0;
                    sig_cnt_d  = '0;
                    pos_d      = '0;
                    neg_d      = '0;
                    rd_d       = '0;
                    dir_d      = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = ST_RESET;
                end
            end
            ST_RESET: begin
                rst_cnt_d = rst_cnt_q + 24'd1;
                if (reset_last) begin
                    if (sh_ap_q == 32'd0) begin
                        dir_d   = cmpr_s;
                        state_d = ST_RUNDOWN;
                    end else begin
                        per_cnt_d  = '0;
                        sig_sw_d   = 1'b1;
                        new_period = 1'b1;
                        state_d    = ST_RUNUP;
                    end
                end
            end
            ST_RUNUP: begin
                if (sig_sw_q) begin
                    sig_cnt_d = sig_cnt_q + 32'd1;
                    if (sig_cnt_d == sh_ap_q) begin
                        sig_sw_d = 1'b0;
                    end
                end
                // Run-up always finishes on a whole period once the aperture has closed.
                if (period_last) begin
                    if (!sig_sw_d) begin
                        dir_d   = cmpr_s;
                        state_d = ST_RUNDOWN;
                    end else begin
                        per_cnt_d  = '0;
                        new_period = 1'b1;
                    end
                end else begin
                    per_cnt_d = per_cnt_q + 16'd1;
                end
            end
            ST_RUNDOWN: begin
                if (cmpr_s != dir_q) begin
                    state_d = ST_DONE;
                end else begin
                    rd_d = rd_q + 1'b1;
                    if (rd_d == '1) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (new_period) begin
            if (cmpr_s) begin
                neg_d = neg_q + 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end

        // Outputs are registered, so they are decoded from the next state.
        case (state_d)
            ST_RUNUP: begin
                refmux_d = new_period ? refmux_for(cmpr_s) : refmux_q;
                latch_d  = 1'b0;
            end
            ST_RUNDOWN: begin
                refmux_d = refmux_for(dir_d);
                latch_d  = 1'b0;
            end
            default: begin
                refmux_d = REFMUX_RESET;
                latch_d  = 1'b1;
            end
        endcase

        if (state_d != ST_RUNUP) begin
            sig_sw_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);

        if (state_d == ST_DONE) begin
            cpos_d  = pos_d;
            cneg_d  = neg_d;
            crd_d   = rd_d;
            csig_d  = sig_cnt_d;
            covf_d  = ovf_d;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sh_reset_q <= '0;
            sh_ap_q    <= '0;
            sh_per_q   <= PMIN;
            rst_cnt_q  <= '0;
            per_cnt_q  <= '0;
            sig_cnt_q  <= '0;
            pos_q      <= '0;
            neg_q      <= '0;
            rd_q       <= '0;
            dir_q      <= 1'b0;
            ovf_q      <= 1'b0;
            refmux_q   <= REFMUX_RESET;
            latch_q    <= 1'b1;
            sig_sw_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            cpos_q     <= '0;
            cneg_q     <= '0;
            crd_q      <= '0;
            csig_q     <= '0;
            covf_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_reset_q <= sh_reset_d;
            sh_ap_q    <= sh_ap_d;
            sh_per_q   <= sh_per_d;
            rst_cnt_q  <= rst_cnt_d;
            per_cnt_q  <= per_cnt_d;
            sig_cnt_q  <= sig_cnt_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            rd_q       <= rd_d;
            dir_q      <= dir_d;
            ovf_q      <= ovf_d;
            refmux_q   <= refmux_d;
            latch_q    <= latch_d;
            sig_sw_q   <= sig_sw_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            cpos_q     <= cpos_d;
            cneg_q     <= cneg_d;
            crd_q      <= crd_d;
            csig_q     <= csig_d;
            covf_q     <= covf_d;
        end
    end

    assign refmux_o        = refmux_q;
    assign cmpr_latch_o    = latch_q;
    assign sig_sw_o        = sig_sw_q;
    assign busy_o          = busy_q;
    assign meas_valid_o    = valid_q;
    assign count_pos_o     = cpos_q;
    assign count_neg_o     = cneg_q;
    assign count_rundown_o = crd_q;
    assign count_sig_o     = csig_q;
    assign overflow_o      = covf_q;
    assign state_o         = state_q;

endmodule
